pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VEC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port fetch_valid  output  1  fetch request valid.
REQ-005 SHALL have port fetch_addr  output  16  fetch address, always equal to pc.
REQ-006 SHALL have port fetch_ready  input  1  fetch consumer accepts the request.
REQ-007 SHALL have port jmp_valid  input  1  redirect request, one-cycle qualified.
REQ-008 SHALL have port jmp_addr  input  16  redirect target.
REQ-009 SHALL have port halt  input  1  stop issuing fetches.
REQ-010 SHALL have port resume  input  1  restart issuing fetches from HALTED.
REQ-011 SHALL have port pc  output  16  current program counter.
REQ-012 SHALL have port wrap  output  1  sticky flag, PC incremented past 16'hFFFF.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, HALTED.
REQ-014 SHALL go IDLE -> FETCH unconditionally on the first clock edge after reset release.
REQ-015 SHALL drive fetch_valid high iff state is FETCH, registered with no combinational path from inputs.
REQ-016 SHALL count a transfer as fetch_valid & fetch_ready in the same cycle.
REQ-017 SHALL, on a transfer without jmp_valid, load pc with pc+1 (mod 2^16) at that edge, one-cycle latency.
REQ-018 SHALL hold pc and fetch_addr stable while fetch_valid & ~fetch_ready and no jump occurs.
REQ-019 SHALL give jmp_valid priority in every state: pc <= jmp_addr, and any same-cycle transfer is squashed (no increment, no wrap update).
REQ-020 SHALL allow a jump to change fetch_addr while fetch_valid is high and not yet accepted (redirect cancels the pending request).
REQ-021 SHALL, in FETCH with halt high, go to HALTED; a same-cycle transfer still completes and increments pc first.
REQ-022 SHALL, in HALTED, keep fetch_valid low, accept jumps (pc updates, state unchanged), and go to FETCH on resume.
REQ-023 SHALL, in HALTED with halt and resume both high, stay HALTED (halt dominates).
REQ-024 SHALL, in IDLE, ignore halt/resume; a jmp_valid in IDLE loads pc.
REQ-025 SHALL set wrap when an increment carries out of bit 15 (pc 16'hFFFF -> 16'h0000); wrap clears only on reset.
REQ-026 SHALL drive pc and fetch_addr from the same register (identical every cycle).

Reset
REQ-027 SHALL, on rst high, immediately force state=IDLE, pc=RESET_VEC, fetch_valid=0, wrap=0, independent of clk.
REQ-028 SHALL abandon any pending request on reset mid-operation; no increment occurs for that cycle.

Structure
REQ-029 SHALL place the state enum (IDLE, FETCH, HALTED) and the 16-bit address width constant in the shared CPU package.
REQ-030 SHALL compute pc+1 by instantiating one Incr16 (in=pc, out=next pc, cy=wrap set), not a '+' operator.

Verification
REQ-031 SHALL check reset: RESET_VEC=16'h0100; release rst -> fetch_valid 0 for one edge, then 1 with fetch_addr=16'h0100, wrap=0.
REQ-032 SHALL check back-pressure: fetch_ready low 3 cycles then high 1 -> fetch_addr held at 16'h0100 for all 4 cycles, then 16'h0101.
REQ-033 SHALL check jump/transfer collision: transfer and jmp_valid with jmp_addr=16'h2000 same cycle -> pc=16'h2000 next cycle, not 16'h2001.
REQ-034 SHALL check wrap: jump to 16'hFFFF, one transfer -> pc=16'h0000, wrap=1; further transfers leave wrap=1.
REQ-035 SHALL check halt: halt with a same-cycle transfer at 16'h0010 -> pc=16'h0011, fetch_valid 0; jump to 16'h0040 while halted -> pc=16'h0040, fetch_valid stays 0; resume -> fetch_valid 1, fetch_addr=16'h0040.
REQ-036 SHALL check async reset mid-stall: assert rst between edges while fetch_valid=1 -> fetch_valid=0 and pc=RESET_VEC before the next edge.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU package: address width and program-counter sequencer state encoding.
package pc_sequencer_pkg;

  localparam int unsigned AddrW = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StHalted = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_sequencer_incr16.sv
// Incr16: 16-bit ripple incrementer built from a half-adder carry chain.
module pc_sequencer_incr16
  import pc_sequencer_pkg::*;
(
  input  logic [AddrW-1:0] in,
  output logic [AddrW-1:0] out,
  output logic             cy
);

  logic carry;

  always_comb begin
    carry = 1'b1;
    out   = '0;
    for (int i = 0; i < AddrW; i++) begin
      out[i] = in[i] ^ carry;
      carry  = carry & in[i];
    end
    cy = carry;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues fetch requests, handles redirects, halt/resume and wrap.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [AddrW-1:0] RESET_VEC = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fetch_valid,
  output logic [AddrW-1:0] fetch_addr,
  input  logic             fetch_ready,
  input  logic             jmp_valid,
  input  logic [AddrW-1:0] jmp_addr,
  input  logic             halt,
  input  logic             resume,
  output logic [AddrW-1:0] pc,
  output logic             wrap
);

  pc_state_e        state_q;
  logic [AddrW-1:0] pc_q;
  logic [AddrW-1:0] pc_inc;
  logic             pc_cy;
  logic             fetch_valid_q;
  logic             wrap_q;
  logic             xfer;

  pc_sequencer_incr16 u_incr16 (
    .in  (pc_q),
    .out (pc_inc),
    .cy  (pc_cy)
  );

  assign xfer = fetch_valid_q & fetch_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_VEC;
      fetch_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (jmp_valid) pc_q <= jmp_addr;
          state_q       <= StFetch;
          fetch_valid_q <= 1'b1;
        end
        StFetch: begin
          // A redirect squashes a same-cycle transfer entirely.
          if (jmp_valid) begin
            pc_q <= jmp_addr;
          end else if (xfer) begin
            pc_q <= pc_inc;
            if (pc_cy) wrap_q <= 1'b1;
          end
          if (halt) begin
            state_q       <= StHalted;
            fetch_valid_q <= 1'b0;
          end
        end
        StHalted: begin
          if (jmp_valid) pc_q <= jmp_addr;
          if (resume && !halt) begin
            state_q       <= StFetch;
            fetch_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= StIdle;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign pc          = pc_q;
  assign fetch_addr  = pc_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic vs a model.
module tb_pc_sequencer;

  localparam logic [15:0] RV = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [15:0] fetch_addr;
  logic        fetch_ready;
  logic        jmp_valid;
  logic [15:0] jmp_addr;
  logic        halt;
  logic        resume;
  logic [15:0] pc;
  logic        wrap;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: mode 0=idle, 1=fetching, 2=halted
  int          m_mode;
  int unsigned m_pc;
  logic        m_wrap;

  pc_sequencer #(.RESET_VEC(RV)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .jmp_valid   (jmp_valid),
    .jmp_addr    (jmp_addr),
    .halt        (halt),
    .resume      (resume),
    .pc          (pc),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 32'(RV);
    m_wrap = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"}, pc, m_pc[15:0]);
    check({tag, ".addr"}, fetch_addr, m_pc[15:0]);
    check({tag, ".valid"}, {15'd0, fetch_valid}, {15'd0, m_mode == 1});
    check({tag, ".wrap"}, {15'd0, wrap}, {15'd0, m_wrap});
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    case (m_mode)
      0: begin
        if (jmp_valid) m_pc = 32'(jmp_addr);
        m_mode = 1;
      end
      1: begin
        if (jmp_valid) begin
          m_pc = 32'(jmp_addr);
        end else if (fetch_ready) begin
          if (m_pc == 32'hFFFF) m_wrap = 1'b1;
          m_pc = (m_pc + 1) % 65536;
        end
        if (halt) m_mode = 2;
      end
      default: begin
        if (jmp_valid) m_pc = 32'(jmp_addr);
        if (resume && !halt) m_mode = 1;
      end
    endcase
    #1;
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; fetch_ready = 1'b0; jmp_valid = 1'b0; jmp_addr = '0;
    halt = 1'b0; resume = 1'b0;
    model_reset();
    #2;
    check("rst.valid", {15'd0, fetch_valid}, 16'd0);
    check("rst.pc", pc, 16'h0100);
    check("rst.wrap", {15'd0, wrap}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rel.valid", {15'd0, fetch_valid}, 16'd0);
    step("first");
    check("first.valid", {15'd0, fetch_valid}, 16'd1);
    check("first.addr", fetch_addr, 16'h0100);

    // Back-pressure
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check("stall.addr", fetch_addr, 16'h0100);
    end
    fetch_ready = 1'b1;
    #1 check("accept.addr_before", fetch_addr, 16'h0100);
    step("accept");
    check("accept.addr", fetch_addr, 16'h0101);

    // Jump collides with a transfer
    jmp_valid = 1'b1; jmp_addr = 16'h2000;
    step("collide");
    check("collide.pc", pc, 16'h2000);

    // Wrap
    fetch_ready = 1'b0; jmp_addr = 16'hFFFF;
    step("jmp_ffff");
    jmp_valid = 1'b0; fetch_ready = 1'b1;
    step("wrap");
    check("wrap.pc", pc, 16'h0000);
    check("wrap.flag", {15'd0, wrap}, 16'd1);
    step("wrap_more");
    check("wrap_more.flag", {15'd0, wrap}, 16'd1);

    // Halt with same-cycle transfer, jump while halted, resume
    jmp_valid = 1'b1; jmp_addr = 16'h0010; fetch_ready = 1'b0;
    step("jmp_10");
    jmp_valid = 1'b0; fetch_ready = 1'b1; halt = 1'b1;
    step("halt");
    check("halt.pc", pc, 16'h0011);
    check("halt.valid", {15'd0, fetch_valid}, 16'd0);
    halt = 1'b0; jmp_valid = 1'b1; jmp_addr = 16'h0040;
    step("halt_jmp");
    check("halt_jmp.pc", pc, 16'h0040);
    check("halt_jmp.valid", {15'd0, fetch_valid}, 16'd0);
    jmp_valid = 1'b0; halt = 1'b1; resume = 1'b1;
    step("halt_dom");
    check("halt_dom.valid", {15'd0, fetch_valid}, 16'd0);
    halt = 1'b0;
    step("resume");
    check("resume.valid", {15'd0, fetch_valid}, 16'd1);
    check("resume.addr", fetch_addr, 16'h0040);
    resume = 1'b0;

    // Async reset between edges while stalled with a pending request
    fetch_ready = 1'b0;
    step("pre_rst");
    #3 rst = 1'b1;
    model_reset();
    #1;
    check("arst.valid", {15'd0, fetch_valid}, 16'd0);
    check("arst.pc", pc, 16'h0100);
    check("arst.wrap", {15'd0, wrap}, 16'd0);
    rst = 1'b0;
    step("arst_rel");

    // Randomized traffic, with jump targets sometimes near the top to exercise wrap
    for (int i = 0; i < 400; i++) begin
      fetch_ready = 1'($urandom_range(0, 1));
      jmp_valid   = ($urandom_range(0, 7) == 0);
      jmp_addr    = ($urandom_range(0, 1) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                               : 16'($urandom);
      halt        = ($urandom_range(0, 9) == 0);
      resume      = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
